// File: rtl/axi4_sram_slave_if.sv
// AXI4 bundle shared by masters and slaves; master/slave modports give direction.
interface axi4_if #(
    parameter int unsigned AXI4_ADDRESS_WIDTH = 32,
    parameter int unsigned AXI4_DATA_WIDTH    = 128,
    parameter int unsigned AXI4_ID_WIDTH      = 4
);
    localparam int unsigned STRB_W = AXI4_DATA_WIDTH / 8;

    // Write address channel
    logic [AXI4_ID_WIDTH-1:0]      awid;
    logic [AXI4_ADDRESS_WIDTH-1:0] awaddr;
    logic [7:0]                    awlen;
    logic [2:0]                    awsize;
    logic [1:0]                    awburst;
    logic                          awvalid;
    logic                          awready;
    // Write data channel
    logic [AXI4_DATA_WIDTH-1:0]    wdata;
    logic [STRB_W-1:0]             wstrb;
    logic                          wlast;
    logic                          wvalid;
    logic                          wready;
    // Write response channel
    logic [AXI4_ID_WIDTH-1:0]      bid;
    logic [1:0]                    bresp;
    logic                          bvalid;
    logic                          bready;
    // Read address channel
    logic [AXI4_ID_WIDTH-1:0]      arid;
    logic [AXI4_ADDRESS_WIDTH-1:0] araddr;
    logic [7:0]                    arlen;
    logic [2:0]                    arsize;
    logic [1:0]                    arburst;
    logic                          arvalid;
    logic                          arready;
    // Read data channel
    logic [AXI4_ID_WIDTH-1:0]      rid;
    logic [AXI4_DATA_WIDTH-1:0]    rdata;
    logic [1:0]                    rresp;
    logic                          rlast;
    logic                          rvalid;
    logic                          rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi4_sram_slave.sv
// AXI4 slave backed by a word-addressed on-chip SRAM; independent write and
// read engines, one outstanding burst each, INCR/WRAP/FIXED addressing.
// Optional: define AXI4_SRAM_SLAVE_RANGE_CHECK_EN to drop/flag beats beyond
// the SRAM size instead of wrapping the word index.
module axi4_sram_slave #(
    parameter int unsigned AXI4_ADDRESS_WIDTH = 32,
    parameter int unsigned AXI4_DATA_WIDTH    = 128,
    parameter int unsigned AXI4_ID_WIDTH      = 4,
    parameter int unsigned MEM_ADDR_BITS      = 10
) (
    input  logic   clk,
    input  logic   rstn,
    axi4_if.slave  s
);
    localparam int unsigned AW    = AXI4_ADDRESS_WIDTH;
    localparam int unsigned DW    = AXI4_DATA_WIDTH;
    localparam int unsigned IW    = AXI4_ID_WIDTH;
    localparam int unsigned SW    = DW / 8;
    localparam int unsigned OFF   = $clog2(SW);
    localparam int unsigned DEPTH = 1 << MEM_ADDR_BITS;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_e;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_e;

    // Address of the beat following addr within the burst.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr, input logic [7:0] len,
                                                input logic [2:0] size, input logic [1:0] burst);
        logic [AW-1:0] step;
        logic [AW-1:0] mask;
        step = AW'(1) << size;
        mask = ((AW'(len) + AW'(1)) << size) - AW'(1);
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~mask) | ((addr + step) & mask);
            default:     next_addr = addr + step;
        endcase
    endfunction

    function automatic logic [MEM_ADDR_BITS-1:0] word_idx(input logic [AW-1:0] addr);
        return MEM_ADDR_BITS'(addr >> OFF);
    endfunction

    logic [DW-1:0] mem_q [DEPTH];

    // Write engine state
    wstate_e                wstate_q, wstate_d;
    logic                   awready_q, awready_d;
    logic                   wready_q, wready_d;
    logic                   bvalid_q, bvalid_d;
    logic [IW-1:0]          bid_q, bid_d;
    logic [1:0]             bresp_q, bresp_d;
    logic [IW-1:0]          wid_q, wid_d;
    logic [AW-1:0]          waddr_q, waddr_d;
    logic [7:0]             wlen_q, wlen_d;
    logic [2:0]             wsize_q, wsize_d;
    logic [1:0]             wburst_q, wburst_d;
    logic [7:0]             wbeat_q, wbeat_d;
    logic                   werr_q, werr_d;
    logic                   mem_we_c;
    logic                   wbeat_err_c;
    logic                   w_oor_c;
    logic [MEM_ADDR_BITS-1:0] mem_widx_c;

    // Read engine state
    rstate_e                rstate_q, rstate_d;
    logic                   arready_q, arready_d;
    logic                   rvalid_q, rvalid_d;
    logic [DW-1:0]          rdata_q, rdata_d;
    logic                   rlast_q, rlast_d;
    logic [IW-1:0]          rid_q, rid_d;
    logic [1:0]             rresp_q, rresp_d;
    logic [AW-1:0]          raddr_q, raddr_d;
    logic [7:0]             rlen_q, rlen_d;
    logic [2:0]             rsize_q, rsize_d;
    logic [1:0]             rburst_q, rburst_d;
    logic [7:0]             rbeat_q, rbeat_d;
    logic [AW-1:0]          rd_addr_c;
    logic [DW-1:0]          rd_data_c;
    logic [1:0]             rd_resp_c;
    logic                   r_oor_c;

`ifdef AXI4_SRAM_SLAVE_RANGE_CHECK_EN
    assign w_oor_c = (waddr_q >> (MEM_ADDR_BITS + OFF)) != '0;
    assign r_oor_c = (rd_addr_c >> (MEM_ADDR_BITS + OFF)) != '0;
`else
    assign w_oor_c = 1'b0;
    assign r_oor_c = 1'b0;
`endif

    assign mem_widx_c = word_idx(waddr_q);

    // SRAM array: byte-enabled write port, contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int unsigned b = 0; b < SW; b++) begin
                if (s.wstrb[b]) mem_q[mem_widx_c][8*b +: 8] <= s.wdata[8*b +: 8];
            end
        end
    end

    // Write engine registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            wid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            wbeat_q   <= '0;
            werr_q    <= 1'b0;
        end else begin
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            wid_q     <= wid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            wbeat_q   <= wbeat_d;
            werr_q    <= werr_d;
        end
    end

    // Write engine next state: AW latch, W beats with WLAST cross-check, B hold.
    always_comb begin
        wstate_d    = wstate_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        bid_d       = bid_q;
        bresp_d     = bresp_q;
        wid_d       = wid_q;
        waddr_d     = waddr_q;
        wlen_d      = wlen_q;
        wsize_d     = wsize_q;
        wburst_d    = wburst_q;
        wbeat_d     = wbeat_q;
        werr_d      = werr_q;
        mem_we_c    = 1'b0;
        wbeat_err_c = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (s.awvalid && awready_q) begin
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    wid_d     = s.awid;
                    waddr_d   = s.awaddr;
                    wlen_d    = s.awlen;
                    wsize_d   = s.awsize;
                    wburst_d  = s.awburst;
                    wbeat_d   = '0;
                    werr_d    = 1'b0;
                    wstate_d  = W_DATA;
                end
            end
            W_DATA: begin
                if (s.wvalid && wready_q) begin
                    wbeat_err_c = (s.wlast != (wbeat_q == wlen_q)) || w_oor_c;
                    mem_we_c    = !w_oor_c;
                    if (wbeat_q == wlen_q) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bid_d    = wid_q;
                        bresp_d  = (werr_q || wbeat_err_c) ? RESP_SLVERR : RESP_OKAY;
                        wstate_d = W_RESP;
                    end else begin
                        werr_d  = werr_q || wbeat_err_c;
                        wbeat_d = wbeat_q + 8'd1;
                        waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
                    end
                end
            end
            W_RESP: begin
                if (s.bready && bvalid_q) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wstate_d  = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Prefetch address: AR address when idle, else the following beat.
    always_comb begin
        if (rstate_q == R_IDLE) rd_addr_c = s.araddr;
        else                    rd_addr_c = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
    end

    assign rd_data_c = r_oor_c ? '0 : mem_q[word_idx(rd_addr_c)];
    assign rd_resp_c = r_oor_c ? RESP_SLVERR : RESP_OKAY;

    // Read engine registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= RESP_OKAY;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rbeat_q   <= '0;
        end else begin
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rbeat_q   <= rbeat_d;
        end
    end

    // Read engine next state: AR latch with first-beat fetch, then one beat per R handshake.
    always_comb begin
        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rresp_d   = rresp_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rsize_d   = rsize_q;
        rburst_d  = rburst_q;
        rbeat_d   = rbeat_q;
        case (rstate_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (s.arvalid && arready_q) begin
                    arready_d = 1'b0;
                    rid_d     = s.arid;
                    raddr_d   = s.araddr;
                    rlen_d    = s.arlen;
                    rsize_d   = s.arsize;
                    rburst_d  = s.arburst;
                    rbeat_d   = '0;
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_data_c;
                    rresp_d   = rd_resp_c;
                    rlast_d   = (s.arlen == 8'd0);
                    rstate_d  = R_DATA;
                end
            end
            R_DATA: begin
                if (s.rready && rvalid_q) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        rresp_d   = RESP_OKAY;
                        arready_d = 1'b1;
                        rstate_d  = R_IDLE;
                    end else begin
                        raddr_d = rd_addr_c;
                        rbeat_d = rbeat_q + 8'd1;
                        rdata_d = rd_data_c;
                        rresp_d = rd_resp_c;
                        rlast_d = ((rbeat_q + 8'd1) == rlen_q);
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    assign s.awready = awready_q;
    assign s.wready  = wready_q;
    assign s.bvalid  = bvalid_q;
    assign s.bid     = bid_q;
    assign s.bresp   = bresp_q;
    assign s.arready = arready_q;
    assign s.rvalid  = rvalid_q;
    assign s.rdata   = rdata_q;
    assign s.rlast   = rlast_q;
    assign s.rid     = rid_q;
    assign s.rresp   = rresp_q;
endmodule
